// File: rtl/rom_arb_pkg.sv
// Shared types and constants for the two-master ROM read arbiter.
package rom_arb_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StAr,
    StR
  } arb_state_e;

  // Width of the master-index field prepended to the master ID on the slave side.
  localparam int unsigned MST_IDX_BITS = 4;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

endpackage

// File: rtl/rom_rd_arbiter_if.sv
// AXI read-channel bundle: AR/R handshakes per port, R payload shared across ports.
interface rom_rd_arbiter_if #(
  parameter int unsigned NumPorts = 1,
  parameter int unsigned IdBits   = 4,
  parameter int unsigned AddrBits = 32,
  parameter int unsigned DataBits = 32,
  parameter int unsigned LenBits  = 4
);
  logic [NumPorts-1:0]               arvalid;
  logic [NumPorts-1:0]               arready;
  logic [NumPorts-1:0][IdBits-1:0]   arid;
  logic [NumPorts-1:0][AddrBits-1:0] araddr;
  logic [NumPorts-1:0][LenBits-1:0]  arlen;
  logic [NumPorts-1:0]               rvalid;
  logic [NumPorts-1:0]               rready;
  logic [IdBits-1:0]                 rid;
  logic [DataBits-1:0]               rdata;
  logic [1:0]                        rresp;
  logic                              rlast;

  modport master (
    output arvalid, arid, araddr, arlen, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, arlen, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-way combinational arbiter: sole requester wins, prio breaks a tie.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       prio_i,
  output logic [1:0] gnt_o,
  output logic       idx_o
);
  always_comb begin
    if (req_i == 2'b11) begin
      gnt_o = prio_i ? 2'b10 : 2'b01;
    end else begin
      gnt_o = req_i;
    end
    idx_o = gnt_o[1];
  end
endmodule

// File: rtl/rom_rd_arbiter.sv
// Two-master AXI read arbiter in front of the ROM slave; one burst outstanding at a time,
// round-robin between instruction fetch (master 0) and data (master 1).
module rom_rd_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ID_BITS   = 4,
  parameter int unsigned IDS_BITS  = 8,
  parameter int unsigned ADDR_BITS = 32,
  parameter int unsigned DATA_BITS = 32,
  parameter int unsigned LEN_BITS  = 4
) (
  input  logic             clk,
  input  logic             rst,
  rom_rd_arbiter_if.slave  m_io,
  rom_rd_arbiter_if.master s_io,
  output logic             rid_err_o
);

  arb_state_e           state_q, state_d;
  logic                 grant_q, grant_d;
  logic                 prio_q, prio_d;
  logic                 rid_err_q, rid_err_d;
  logic [ID_BITS-1:0]   id_q, id_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]  len_q, len_d;
  logic [1:0]           gnt;
  logic                 gnt_idx;
  logic                 r_hs;

  rr_arb2 u_rr_arb2 (
    .req_i (m_io.arvalid),
    .prio_i(prio_q),
    .gnt_o (gnt),
    .idx_o (gnt_idx)
  );

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    prio_d       = prio_q;
    rid_err_d    = rid_err_q;
    id_d         = id_q;
    addr_d       = addr_q;
    len_d        = len_q;
    r_hs         = 1'b0;
    m_io.arready = 2'b00;
    m_io.rvalid  = 2'b00;
    m_io.rid     = '0;
    m_io.rdata   = {DATA_BITS{1'b0}};
    m_io.rresp   = AXI_RESP_OKAY;
    m_io.rlast   = 1'b0;
    s_io.arvalid = 1'b0;
    s_io.arid    = {MST_IDX_BITS'(grant_q), id_q};
    s_io.araddr  = addr_q;
    s_io.arlen   = len_q;
    s_io.rready  = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Gated by rst so ready drops immediately while reset is held.
        m_io.arready = gnt & {2{~rst}};
        if (gnt != 2'b00) begin
          grant_d = gnt_idx;
          id_d    = m_io.arid[gnt_idx];
          addr_d  = m_io.araddr[gnt_idx];
          len_d   = m_io.arlen[gnt_idx];
          state_d = StAr;
        end
      end
      StAr: begin
        s_io.arvalid = 1'b1;
        if (s_io.arready[0]) begin
          state_d = StR;
        end
      end
      StR: begin
        s_io.rready          = m_io.rready[grant_q];
        m_io.rvalid[grant_q] = s_io.rvalid[0];
        m_io.rid             = s_io.rid[ID_BITS-1:0];
        m_io.rdata           = s_io.rdata;
        m_io.rresp           = s_io.rresp;
        m_io.rlast           = s_io.rlast;
        r_hs                 = s_io.rvalid[0] & m_io.rready[grant_q];
        if (r_hs) begin
          if (s_io.rid[IDS_BITS-1:ID_BITS] != MST_IDX_BITS'(grant_q)) begin
            rid_err_d = 1'b1;
          end
          if (s_io.rlast) begin
            state_d = StIdle;
            prio_d  = ~grant_q;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      grant_q   <= 1'b0;
      prio_q    <= 1'b0;
      rid_err_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      prio_q    <= prio_d;
      rid_err_q <= rid_err_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
    end
  end

  assign rid_err_o = rid_err_q;

endmodule

// File: tb/tb_rom_rd_arbiter.sv
// Self-checking bench: master/slave models, AR and R scoreboards, table of request patterns.
module tb_rom_rd_arbiter;
  import rom_arb_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rid_err;

  always #5 clk = ~clk;

  rom_rd_arbiter_if #(.NumPorts(2), .IdBits(4), .AddrBits(32), .DataBits(32), .LenBits(4)) m_if();
  rom_rd_arbiter_if #(.NumPorts(1), .IdBits(8), .AddrBits(32), .DataBits(32), .LenBits(4)) s_if();

  rom_rd_arbiter #(
    .ID_BITS  (4),
    .IDS_BITS (8),
    .ADDR_BITS(32),
    .DATA_BITS(32),
    .LEN_BITS (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m_io     (m_if),
    .s_io     (s_if),
    .rid_err_o(rid_err)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } req_t;

  typedef struct {
    int          m;
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  typedef struct {
    logic [7:0]  arid;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_t;

  typedef struct {
    logic [1:0]  req;
    logic [3:0]  id0;
    logic [3:0]  id1;
    logic [31:0] a0;
    logic [31:0] a1;
    logic [3:0]  l0;
    logic [3:0]  l1;
    bit          bp;
    int          first;
  } row_t;

  req_t  mq0[$];
  req_t  mq1[$];
  beat_t sb[$];
  ar_t   arq[$];
  int    order[$];
  int    ord_cyc[$];
  int    last_cyc[$];

  bit          sl_act;
  logic [7:0]  sl_id;
  logic [31:0] sl_addr;
  logic [3:0]  sl_len;
  logic [3:0]  sl_beat;
  bit          fault_rid;
  bit          toggle;
  int          cyc;
  int          last_mhs_cyc;
  int          n_checks;
  int          n_pass;
  row_t        rows[8];

  function automatic logic [31:0] beat_data(input logic [31:0] a, input logic [3:0] b);
    return a ^ ({28'd0, b} * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  function automatic bit busy();
    return (mq0.size() != 0) || (mq1.size() != 0) || sl_act || (sb.size() != 0) ||
           (arq.size() != 0);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic push_req(input int m, input logic [3:0] id, input logic [31:0] addr,
                          input logic [3:0] len);
    req_t r;
    r.id   = id;
    r.addr = addr;
    r.len  = len;
    if (m == 0) mq0.push_back(r);
    else mq1.push_back(r);
  endtask

  task automatic drive();
    m_if.arvalid = {mq1.size() != 0, mq0.size() != 0};
    m_if.arid    = '0;
    m_if.araddr  = '0;
    m_if.arlen   = '0;
    if (mq0.size() != 0) begin
      m_if.arid[0]   = mq0[0].id;
      m_if.araddr[0] = mq0[0].addr;
      m_if.arlen[0]  = mq0[0].len;
    end
    if (mq1.size() != 0) begin
      m_if.arid[1]   = mq1[0].id;
      m_if.araddr[1] = mq1[0].addr;
      m_if.arlen[1]  = mq1[0].len;
    end
    m_if.rready  = toggle ? ((cyc % 2 == 1) ? 2'b11 : 2'b00) : 2'b11;
    s_if.arready = 1'b1;
    s_if.rvalid  = sl_act;
    s_if.rid     = fault_rid ? {4'h1, sl_id[3:0]} : sl_id;
    s_if.rdata   = sl_act ? beat_data(sl_addr, sl_beat) : 32'h0;
    s_if.rresp   = sl_beat[1:0];
    s_if.rlast   = sl_act && (sl_beat == sl_len);
  endtask

  task automatic sample();
    logic [1:0] mhs, mrh, exp_rv;
    logic       shs, sar;
    req_t       r;
    beat_t      e;
    ar_t        a;
    mhs = m_if.arvalid & m_if.arready;
    mrh = m_if.rvalid & m_if.rready;
    shs = s_if.rvalid[0] & s_if.rready[0];
    sar = s_if.arvalid[0] & s_if.arready[0];

    exp_rv = 2'b00;
    if (sl_act && sb.size() != 0) exp_rv = (sb[0].m == 1) ? 2'b10 : 2'b01;
    check("m_rvalid", 64'(m_if.rvalid), 64'(exp_rv));
    if (sl_act && sb.size() != 0)
      check("s_rready_mirror", 64'(s_if.rready[0]), 64'(m_if.rready[sb[0].m]));
    if (shs || mrh != 2'b00) check("beat_pair", 64'(shs), 64'(mrh != 2'b00));
    if (mrh != 2'b00) begin
      if (sb.size() == 0) begin
        check("beat_extra", 64'(mrh), 64'(0));
      end else begin
        e = sb.pop_front();
        check("beat_master", 64'(mrh), 64'((e.m == 1) ? 2'b10 : 2'b01));
        check("m_rid", 64'(m_if.rid), 64'(e.id));
        check("m_rdata", 64'(m_if.rdata), 64'(e.data));
        check("m_rresp", 64'(m_if.rresp), 64'(e.resp));
        check("m_rlast", 64'(m_if.rlast), 64'(e.last));
      end
    end
    if (shs) begin
      if (s_if.rlast) begin
        sl_act = 1'b0;
        last_cyc.push_back(cyc);
      end else begin
        sl_beat++;
      end
    end

    if (sar) begin
      if (arq.size() == 0) begin
        check("ar_extra", 64'(s_if.arvalid), 64'(0));
      end else begin
        a = arq.pop_front();
        check("s_arid", 64'(s_if.arid[0]), 64'(a.arid));
        check("s_araddr", 64'(s_if.araddr[0]), 64'(a.addr));
        check("s_arlen", 64'(s_if.arlen[0]), 64'(a.len));
        check("ar_latency", 64'(cyc - last_mhs_cyc), 64'(1));
      end
      sl_act  = 1'b1;
      sl_id   = s_if.arid[0];
      sl_addr = s_if.araddr[0];
      sl_len  = s_if.arlen[0];
      sl_beat = 4'd0;
    end

    if (mhs != 2'b00) check("arready_onehot", 64'($countones(mhs)), 64'(1));
    for (int m = 0; m < 2; m++) begin
      if (mhs[m]) begin
        r = (m == 0) ? mq0.pop_front() : mq1.pop_front();
        order.push_back(m);
        ord_cyc.push_back(cyc);
        last_mhs_cyc = cyc;
        a.arid = {4'(m), r.id};
        a.addr = r.addr;
        a.len  = r.len;
        arq.push_back(a);
        for (int b = 0; b <= int'(r.len); b++) begin
          e.m    = m;
          e.id   = r.id;
          e.data = beat_data(r.addr, 4'(b));
          e.resp = 2'(b);
          e.last = (b == int'(r.len));
          sb.push_back(e);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    drive();
    @(negedge clk);
    sample();
  endtask

  task automatic run_idle(input int budget, input string name);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (busy() && n < budget);
    check({name, "_done"}, 64'(busy()), 64'(0));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_m_arready"}, 64'(m_if.arready), 64'(0));
    check({tag, "_m_rvalid"}, 64'(m_if.rvalid), 64'(0));
    check({tag, "_s_arvalid"}, 64'(s_if.arvalid), 64'(0));
    check({tag, "_s_rready"}, 64'(s_if.rready), 64'(0));
    check({tag, "_s_arid"}, 64'(s_if.arid[0]), 64'(0));
    check({tag, "_s_araddr"}, 64'(s_if.araddr[0]), 64'(0));
    check({tag, "_s_arlen"}, 64'(s_if.arlen[0]), 64'(0));
    check({tag, "_m_rdata"}, 64'(m_if.rdata), 64'(0));
    check({tag, "_rid_err"}, 64'(rid_err), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rows[0] = '{req: 2'b11, id0: 4'h2, id1: 4'hA, a0: 32'h10, a1: 32'h3000,
                l0: 4'd3, l1: 4'd1, bp: 1'b0, first: 0};
    rows[1] = '{req: 2'b01, id0: 4'h2, id1: 4'h0, a0: 32'h10, a1: 32'h0,
                l0: 4'd3, l1: 4'd0, bp: 1'b0, first: 0};
    rows[2] = '{req: 2'b10, id0: 4'h0, id1: 4'h5, a0: 32'h0, a1: 32'h200,
                l0: 4'd0, l1: 4'd0, bp: 1'b0, first: 1};
    rows[3] = '{req: 2'b11, id0: 4'h7, id1: 4'hF, a0: 32'hFFFF_FFF0, a1: 32'h8000_0000,
                l0: 4'd2, l1: 4'd2, bp: 1'b0, first: 0};
    rows[4] = '{req: 2'b11, id0: 4'h1, id1: 4'h4, a0: 32'h400, a1: 32'h500,
                l0: 4'd7, l1: 4'd3, bp: 1'b1, first: 0};
    rows[5] = '{req: 2'b10, id0: 4'h0, id1: 4'h6, a0: 32'h0, a1: 32'h1234_5678,
                l0: 4'd0, l1: 4'd15, bp: 1'b1, first: 1};
    rows[6] = '{req: 2'b01, id0: 4'h0, id1: 4'h0, a0: 32'h20, a1: 32'h0,
                l0: 4'd0, l1: 4'd0, bp: 1'b0, first: 0};
    rows[7] = '{req: 2'b11, id0: 4'h3, id1: 4'hC, a0: 32'h30, a1: 32'h40,
                l0: 4'd1, l1: 4'd0, bp: 1'b0, first: 1};

    n_checks = 0;
    n_pass = 0;
    cyc = 0;
    last_mhs_cyc = -10;
    sl_act = 1'b0;
    sl_id = '0;
    sl_addr = '0;
    sl_len = '0;
    sl_beat = '0;
    fault_rid = 1'b0;
    toggle = 1'b0;
    drive();
    m_if.arvalid = 2'b11;  // requests while reset is held must not see arready
    #2;
    check_all_zero("reset");
    m_if.arvalid = 2'b00;
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      order.delete();
      ord_cyc.delete();
      last_cyc.delete();
      toggle = rows[i].bp;
      if (rows[i].req[0]) push_req(0, rows[i].id0, rows[i].a0, rows[i].l0);
      if (rows[i].req[1]) push_req(1, rows[i].id1, rows[i].a1, rows[i].l1);
      run_idle(400, "row");
      check("row_grants", 64'(order.size()), 64'((rows[i].req == 2'b11) ? 2 : 1));
      if (order.size() > 0) check("row_first", 64'(order[0]), 64'(rows[i].first));
      if (rows[i].req == 2'b11 && order.size() > 1 && last_cyc.size() > 0) begin
        check("row_second", 64'(order[1]), 64'(1 - rows[i].first));
        check("idle_bubble", 64'(ord_cyc[1] - last_cyc[0]), 64'(1));
      end
      check("row_rid_err", 64'(rid_err), 64'(0));
    end
    toggle = 1'b0;

    // m1 keeps requesting, m0 asks once mid-burst: m0 must win the next arbitration
    order.delete();
    push_req(1, 4'h1, 32'h1000, 4'd2);
    push_req(1, 4'h2, 32'h1100, 4'd2);
    push_req(1, 4'h3, 32'h1200, 4'd2);
    tick();
    tick();
    push_req(0, 4'h8, 32'h2000, 4'd1);
    run_idle(400, "starve");
    check("starve_count", 64'(order.size()), 64'(4));
    if (order.size() == 4) begin
      check("starve_g0", 64'(order[0]), 64'(1));
      check("starve_g1", 64'(order[1]), 64'(0));
      check("starve_g2", 64'(order[2]), 64'(1));
    end

    // Slave returns a foreign master index while grant=0
    fault_rid = 1'b1;
    push_req(0, 4'h4, 32'h80, 4'd1);
    for (int n = 0; n < 20 && !sl_act; n++) tick();
    check("rid_err_pre", 64'(rid_err), 64'(0));
    tick();
    tick();
    check("rid_err_rise", 64'(rid_err), 64'(1));
    run_idle(100, "fault");
    fault_rid = 1'b0;
    push_req(1, 4'h5, 32'h90, 4'd0);
    run_idle(100, "post_fault");
    check("rid_err_sticky", 64'(rid_err), 64'(1));

    // Reset during beat 2 of a 4-beat burst
    push_req(0, 4'h2, 32'h40, 4'd3);
    for (int n = 0; n < 40 && !(sl_act && sb.size() == 2); n++) tick();
    check("mid_reset_state", 64'(m_if.rvalid), 64'(2'b01));
    #2;
    rst = 1'b1;
    #1;
    check_all_zero("mid_reset");
    sb.delete();
    arq.delete();
    mq0.delete();
    mq1.delete();
    sl_act = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    order.delete();
    push_req(1, 4'h9, 32'h900, 4'd1);
    run_idle(100, "after_reset");
    check("after_reset_grants", 64'(order.size()), 64'(1));
    if (order.size() > 0) check("after_reset_first", 64'(order[0]), 64'(1));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
